spis: RTL

//  SPI slave peripheral on the picorv32 native memory bus: the target-side counterpart of spim.

---
 rtl/spis.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spis.sv
// SPI slave peripheral on the picorv32 native memory bus.
// Receives mode-0, MSB-first byte frames into an RX FIFO and returns bytes
// from a TX FIFO. When the TX FIFO is empty at a byte start, IDLE_BYTE is sent.
// The SPI pins are oversampled in the clk domain, so f_ck must not exceed f_clk/8.
// Optional feature macro: SPIS_IRQ_EN adds the irq output and the CTRL[3:2]
// interrupt enables.
module spis #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [7:0]  IDLE_BYTE  = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        spi_cs,
    input  logic        spi_ck,
    input  logic [3:0]  spi_di,
    output logic [3:0]  spi_do,
    output logic [3:0]  spi_oe
`ifdef SPIS_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

    logic cs_s1_r, cs_s2_r, cs_d_r, ck_s1_r, ck_s2_r, ck_d_r, di_s1_r, di_s2_r;
    logic ck_rise_s, ck_fall_s, cs_fall_s;
    state_t state_r;
    logic [7:0] tx_sh_r, rx_sh_r, tx_head_s, rx_byte_s;
    logic [3:0] bit_cnt_r;
    logic miso_r, oe_r;
    logic ready_r;
    logic [31:0] rdata_r, rdata_s;
    logic ctrl_en_r, rx_ovf_r, tx_udf_r;
    logic [1:0] ctrl_ie_s;
    logic [7:0] rx_mem_r [FIFO_DEPTH];
    logic [7:0] tx_mem_r [FIFO_DEPTH];
    logic [AW:0] rx_wp_r, rx_rp_r, tx_wp_r, tx_rp_r, rx_level_s;
    logic rx_empty_s, rx_full_s, tx_empty_s, tx_full_s;
    logic acc_s, we_s, fsm_load_s;
    logic rx_pop_s, rx_push_req_s, rx_push_s, tx_push_req_s, tx_push_s, tx_pop_s;
    logic rx_ovf_set_s, tx_udf_set_s, flush_s, w1c_s;
    logic [1:0] sel_s;
    logic unused_s;

    assign unused_s = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:8], spi_di[3:1]};

    // Status derived from pointers; full when pointers differ only in the MSB.
    assign rx_level_s = rx_wp_r - rx_rp_r;
    assign rx_empty_s = (rx_wp_r == rx_rp_r);
    assign rx_full_s  = (rx_wp_r[AW] != rx_rp_r[AW]) && (rx_wp_r[AW-1:0] == rx_rp_r[AW-1:0]);
    assign tx_empty_s = (tx_wp_r == tx_rp_r);
    assign tx_full_s  = (tx_wp_r[AW] != tx_rp_r[AW]) && (tx_wp_r[AW-1:0] == tx_rp_r[AW-1:0]);

    assign ck_rise_s = ck_s2_r & ~ck_d_r;
    assign ck_fall_s = ~ck_s2_r & ck_d_r;
    assign cs_fall_s = cs_d_r & ~cs_s2_r;
    assign rx_byte_s = {rx_sh_r[6:0], di_s2_r};
    assign tx_head_s = tx_empty_s ? IDLE_BYTE : tx_mem_r[tx_rp_r[AW-1:0]];

    // Bus accesses act at the edge that raises mem_ready, so each access acts once.
    assign acc_s = mem_valid & ~ready_r;
    assign we_s  = |mem_wstrb;
    assign sel_s = mem_addr[3:2];

    assign fsm_load_s    = (state_r == LOAD) & ~cs_s2_r;
    assign rx_pop_s      = acc_s & ~we_s & (sel_s == 2'd0) & ~rx_empty_s;
    assign rx_push_req_s = (state_r == SHIFT) & ~cs_s2_r & ck_rise_s & (bit_cnt_r == 4'd7);
    assign rx_push_s     = rx_push_req_s & (~rx_full_s | rx_pop_s);
    assign rx_ovf_set_s  = rx_push_req_s & ~rx_push_s;
    assign tx_pop_s      = fsm_load_s & ~tx_empty_s;
    assign tx_udf_set_s  = fsm_load_s & tx_empty_s;
    assign tx_push_req_s = acc_s & we_s & (sel_s == 2'd0);
    assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
    assign flush_s       = acc_s & we_s & (sel_s == 2'd2) & mem_wdata[1];
    assign w1c_s         = acc_s & we_s & (sel_s == 2'd1);

    // Read-data mux for the register file.
    always_comb begin
        rdata_s = 32'h0;
        case (sel_s)
            2'd0: rdata_s = {24'h0, (rx_empty_s ? 8'h00 : rx_mem_r[rx_rp_r[AW-1:0]])};
            2'd1: rdata_s = {16'h0, 8'(rx_level_s), 1'b0, tx_udf_r, rx_ovf_r, ~cs_s2_r,
                             tx_full_s, tx_empty_s, rx_full_s, rx_empty_s};
            2'd2: rdata_s = {28'h0, ctrl_ie_s, 1'b0, ctrl_en_r};
            default: rdata_s = 32'h0;
        endcase
    end

    // Two-flop synchronisers for the SPI pins plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s1_r <= 1'b1; cs_s2_r <= 1'b1; cs_d_r <= 1'b1;
            ck_s1_r <= 1'b0; ck_s2_r <= 1'b0; ck_d_r <= 1'b0;
            di_s1_r <= 1'b0; di_s2_r <= 1'b0;
        end else begin
            cs_s1_r <= spi_cs;  cs_s2_r <= cs_s1_r; cs_d_r <= cs_s2_r;
            ck_s1_r <= spi_ck;  ck_s2_r <= ck_s1_r; ck_d_r <= ck_s2_r;
            di_s1_r <= spi_di[0]; di_s2_r <= di_s1_r;
        end
    end

    // Byte framing FSM; a deasserted chip select always wins and drops the partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tx_sh_r   <= 8'h00;
            rx_sh_r   <= 8'h00;
            bit_cnt_r <= 4'd0;
            miso_r    <= 1'b0;
            oe_r      <= 1'b0;
        end else if (cs_s2_r) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            miso_r    <= 1'b0;
            oe_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    miso_r <= 1'b0;
                    oe_r   <= 1'b0;
                    if (cs_fall_s && ctrl_en_r) begin
                        state_r <= LOAD;
                    end
                end
                LOAD: begin
                    tx_sh_r   <= tx_head_s;
                    miso_r    <= tx_head_s[7];
                    oe_r      <= 1'b1;
                    bit_cnt_r <= 4'd0;
                    state_r   <= SHIFT;
                end
                SHIFT: begin
                    if (ck_rise_s) begin
                        rx_sh_r   <= rx_byte_s;
                        bit_cnt_r <= bit_cnt_r + 4'd1;
                    end else if (ck_fall_s) begin
                        if (bit_cnt_r == 4'd8) begin
                            if (ctrl_en_r) begin
                                state_r <= LOAD;
                            end else begin
                                state_r <= IDLE;
                                miso_r  <= 1'b0;
                                oe_r    <= 1'b0;
                            end
                        end else begin
                            tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                            miso_r  <= tx_sh_r[6];
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    miso_r  <= 1'b0;
                    oe_r    <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and storage; flush empties both FIFOs and overrides traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_wp_r <= '0; rx_rp_r <= '0; tx_wp_r <= '0; tx_rp_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rx_mem_r[i] <= 8'h00;
                tx_mem_r[i] <= 8'h00;
            end
        end else if (flush_s) begin
            rx_wp_r <= '0; rx_rp_r <= '0; tx_wp_r <= '0; tx_rp_r <= '0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wp_r[AW-1:0]] <= rx_byte_s;
                rx_wp_r <= rx_wp_r + 1'b1;
            end
            if (rx_pop_s) begin
                rx_rp_r <= rx_rp_r + 1'b1;
            end
            if (tx_push_s) begin
                tx_mem_r[tx_wp_r[AW-1:0]] <= mem_wdata[7:0];
                tx_wp_r <= tx_wp_r + 1'b1;
            end
            if (tx_pop_s) begin
                tx_rp_r <= tx_rp_r + 1'b1;
            end
        end
    end

    // Bus handshake, registered read data, control and sticky flags (set beats clear).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r   <= 1'b0;
            rdata_r   <= 32'h0;
            ctrl_en_r <= 1'b0;
            rx_ovf_r  <= 1'b0;
            tx_udf_r  <= 1'b0;
        end else begin
            ready_r <= acc_s;
            rdata_r <= acc_s ? rdata_s : 32'h0;
            if (acc_s && we_s && (sel_s == 2'd2)) begin
                ctrl_en_r <= mem_wdata[0];
            end
            if (rx_ovf_set_s) begin
                rx_ovf_r <= 1'b1;
            end else if (w1c_s && mem_wdata[5]) begin
                rx_ovf_r <= 1'b0;
            end
            if (tx_udf_set_s) begin
                tx_udf_r <= 1'b1;
            end else if (w1c_s && mem_wdata[6]) begin
                tx_udf_r <= 1'b0;
            end
        end
    end

`ifdef SPIS_IRQ_EN
    logic [1:0] ctrl_ie_r;
    logic irq_r;
    assign ctrl_ie_s = ctrl_ie_r;
    assign irq = irq_r;

    // Interrupt enables and the registered interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_ie_r <= 2'b00;
            irq_r     <= 1'b0;
        end else begin
            if (acc_s && we_s && (sel_s == 2'd2)) begin
                ctrl_ie_r <= mem_wdata[3:2];
            end
            irq_r <= (ctrl_ie_r[0] & ~rx_empty_s) | (ctrl_ie_r[1] & tx_empty_s) | rx_ovf_r;
        end
    end
`else
    assign ctrl_ie_s = 2'b00;
`endif

    assign mem_ready = ready_r;
    assign mem_rdata = rdata_r;
    assign spi_do    = {2'b00, miso_r, 1'b0};
    assign spi_oe    = {2'b00, oe_r, 1'b0};

endmodule
